// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises each accepted payload as preamble 1,0,1 + payload MSB first, then idles GAP_CYCLES.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_pattern_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_data_out,
  output logic                  o_bit_valid,
  output logic                  o_frame_done
);
  localparam int CNT_MAX = (DATA_WIDTH > GAP_CYCLES) ? ((DATA_WIDTH > 3) ? DATA_WIDTH : 3)
                                                     : ((GAP_CYCLES > 3) ? GAP_CYCLES : 3);
  localparam int CW = $clog2(CNT_MAX);
`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, GAP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, GAP} state_t;
`endif
  state_t                state_q, state_d, after_frame;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  rdy_q, dout_q, bv_q, done_q;
  logic                  rdy_d, dout_d, bv_d, done_d, last_bit;
`ifdef SEQ_TX_PARITY_EN
  logic                  par_q, par_d;
`endif
  assign after_frame = (GAP_CYCLES == 0) ? IDLE : GAP;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    last_bit = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: if (i_valid && rdy_q) begin
        state_d = PREAMBLE;
        cnt_d   = '0;
        sh_d    = i_data;
`ifdef SEQ_TX_PARITY_EN
        par_d   = ^i_data;
`endif
      end
      PREAMBLE: begin
        state_d = (cnt_q == CW'(2)) ? DATA : PREAMBLE;
        cnt_d   = (cnt_q == CW'(2)) ? '0 : cnt_q + 1'b1;
      end
      DATA: if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        cnt_d = '0;
`ifdef SEQ_TX_PARITY_EN
        state_d = PARITY;
`else
        state_d  = after_frame;
        last_bit = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
        sh_d  = sh_q << 1;
      end
`ifdef SEQ_TX_PARITY_EN
      PARITY: begin
        state_d  = after_frame;
        last_bit = 1'b1;
      end
`endif
      GAP: begin
        state_d = (cnt_q == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
        cnt_d   = (cnt_q == CW'(GAP_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they appear registered in the cycle they describe.
    rdy_d  = (state_d == IDLE);
    bv_d   = (state_d != IDLE) && (state_d != GAP);
    done_d = last_bit;
`ifdef SEQ_TX_PARITY_EN
    dout_d = (state_d == PREAMBLE) ? (cnt_d != CW'(1)) :
             (state_d == DATA)     ? sh_d[DATA_WIDTH-1] :
             (state_d == PARITY)   ? par_d : 1'b0;
`else
    dout_d = (state_d == PREAMBLE) ? (cnt_d != CW'(1)) :
             (state_d == DATA)     ? sh_d[DATA_WIDTH-1] : 1'b0;
`endif
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b0;
      dout_q  <= 1'b0;
      bv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
      bv_q    <= bv_d;
      done_q  <= done_d;
    end
  end
`ifdef SEQ_TX_PARITY_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`endif
  assign o_ready      = rdy_q;
  assign o_data_out   = dout_q;
  assign o_bit_valid  = bv_q;
  assign o_frame_done = done_q;
endmodule
